// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory,
// latches the fetched word and presents its opcode (CODOP) downstream.
// Ports: CLK, RST_N (sync, active low), FONTECP/DESVIO_END/SALTO_END select
// the next PC; MEM_REQ/MEM_END/MEM_PRONTO/MEM_DADO form the memory handshake;
// PC, INSTR, CODOP, INSTR_VALIDA go to the control unit.
// Optional macro PARADA_EN: opcode 4'b1111 parks the FSM in PARADO until reset.
module busca_instrucao #(
   parameter int LARG_PC   = 8,
   parameter int LARG_INST = 16
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [1:0]           FONTECP,
   input  logic [LARG_PC-1:0]   DESVIO_END,
   input  logic [LARG_PC-1:0]   SALTO_END,
   input  logic                 MEM_PRONTO,
   input  logic [LARG_INST-1:0] MEM_DADO,
   output logic                 MEM_REQ,
   output logic [LARG_PC-1:0]   MEM_END,
   output logic [LARG_PC-1:0]   PC,
   output logic [LARG_INST-1:0] INSTR,
   output logic [3:0]           CODOP,
   output logic                 INSTR_VALIDA
);

`ifdef PARADA_EN
   typedef enum logic [2:0] {
      OCIOSO,
      BUSCA,
      DECOD,
      ATUALIZA,
      PARADO
   } estado_t;
`else
   typedef enum logic [1:0] {
      OCIOSO,
      BUSCA,
      DECOD,
      ATUALIZA
   } estado_t;
`endif

   estado_t              estado_q, estado_d;
   logic [LARG_PC-1:0]   pc_q, pc_d;
   logic [LARG_INST-1:0] instr_q, instr_d;
   logic                 req_q, req_d;
   logic                 valida_q, valida_d;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         estado_q <= OCIOSO;
         pc_q     <= '0;
         instr_q  <= '0;
         req_q    <= 1'b0;
         valida_q <= 1'b0;
      end else begin
         estado_q <= estado_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         req_q    <= req_d;
         valida_q <= valida_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      req_d    = req_q;
      valida_d = 1'b0;
      unique case (estado_q)
         OCIOSO: begin
            req_d    = 1'b1;
            estado_d = BUSCA;
         end
         BUSCA: begin
            req_d = 1'b1;
            if (MEM_PRONTO) begin
               instr_d  = MEM_DADO;
               req_d    = 1'b0;
               valida_d = 1'b1;
               estado_d = DECOD;
            end
         end
         DECOD: begin
            estado_d = ATUALIZA;
`ifdef PARADA_EN
            if (instr_q[LARG_INST-1 -: 4] == 4'b1111) begin
               estado_d = PARADO;
            end
`endif
         end
         ATUALIZA: begin
            // FONTECP was registered by control during DECOD.
            unique case (FONTECP)
               2'b01:   pc_d = DESVIO_END;
               2'b10:   pc_d = SALTO_END;
               default: pc_d = pc_q + LARG_PC'(1);
            endcase
            req_d    = 1'b1;
            estado_d = BUSCA;
         end
`ifdef PARADA_EN
         PARADO: begin
            req_d = 1'b0;
         end
`endif
         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   assign MEM_REQ      = req_q;
   assign MEM_END      = pc_q;
   assign PC           = pc_q;
   assign INSTR        = instr_q;
   assign CODOP        = instr_q[LARG_INST-1 -: 4];
   assign INSTR_VALIDA = valida_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: reset, wait states, branch/jump,
// wrap-around, reset mid-handshake and halt opcode.
module tb_busca_instrucao;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [1:0]  FONTECP;
   logic [7:0]  DESVIO_END;
   logic [7:0]  SALTO_END;
   logic        MEM_PRONTO;
   logic [15:0] MEM_DADO;
   logic        MEM_REQ;
   logic [7:0]  MEM_END;
   logic [7:0]  PC;
   logic [15:0] INSTR;
   logic [3:0]  CODOP;
   logic        INSTR_VALIDA;

   int erros = 0;
   int checks = 0;

   busca_instrucao #(.LARG_PC(8), .LARG_INST(16)) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .FONTECP(FONTECP),
      .DESVIO_END(DESVIO_END),
      .SALTO_END(SALTO_END),
      .MEM_PRONTO(MEM_PRONTO),
      .MEM_DADO(MEM_DADO),
      .MEM_REQ(MEM_REQ),
      .MEM_END(MEM_END),
      .PC(PC),
      .INSTR(INSTR),
      .CODOP(CODOP),
      .INSTR_VALIDA(INSTR_VALIDA)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         erros++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Starts in BUSCA; one-cycle memory; ends in BUSCA at the new PC.
   task automatic busca(input logic [15:0] dado, input logic [1:0] fcp,
                        input logic [7:0] desvio, input logic [7:0] salto);
      MEM_PRONTO = 1'b1;
      MEM_DADO   = dado;
      tick();
      chk("cap_valida", INSTR_VALIDA, 1);
      chk("cap_codop", CODOP, dado[15:12]);
      MEM_PRONTO = 1'b0;
      FONTECP    = fcp;
      DESVIO_END = desvio;
      SALTO_END  = salto;
      tick();
      tick();
      chk("nxt_req", MEM_REQ, 1);
   endtask

   initial begin
      RST_N = 1'b0;
      FONTECP = 2'b00;
      DESVIO_END = '0;
      SALTO_END = '0;
      MEM_PRONTO = 1'b0;
      MEM_DADO = '0;
      tick();
      tick();
      chk("rst_pc", PC, 0);
      chk("rst_instr", INSTR, 0);
      chk("rst_codop", CODOP, 0);
      chk("rst_req", MEM_REQ, 0);
      chk("rst_valida", INSTR_VALIDA, 0);

      RST_N = 1'b1;
      tick();
      chk("first_req", MEM_REQ, 1);
      chk("first_end", MEM_END, 0);
      MEM_PRONTO = 1'b1;
      MEM_DADO = 16'h1234;
      tick();
      chk("c1_valida", INSTR_VALIDA, 1);
      chk("c1_codop", CODOP, 4'h1);
      chk("c1_instr", INSTR, 16'h1234);
      chk("c1_req", MEM_REQ, 0);
      MEM_PRONTO = 1'b0;
      tick();
      chk("c1_pulse", INSTR_VALIDA, 0);
      chk("c1_pc_hold", PC, 0);
      tick();
      chk("c1_pc", PC, 1);
      chk("c1_req2", MEM_REQ, 1);

      MEM_DADO = 16'hA5A5;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("ws_req", MEM_REQ, 1);
         chk("ws_end", MEM_END, 1);
         chk("ws_instr", INSTR, 16'h1234);
         chk("ws_valida", INSTR_VALIDA, 0);
      end
      MEM_PRONTO = 1'b1;
      MEM_DADO = 16'h2ABC;
      tick();
      chk("ws_cap", INSTR, 16'h2ABC);
      chk("ws_valida1", INSTR_VALIDA, 1);
      MEM_DADO = 16'h7777;
      tick();
      chk("ign_decod", INSTR, 16'h2ABC);
      chk("ign_valida", INSTR_VALIDA, 0);
      tick();
      chk("ign_atual", INSTR, 16'h2ABC);
      chk("ign_pc", PC, 2);
      MEM_PRONTO = 1'b0;

      busca(16'h3000, 2'b10, 8'h00, 8'h10);
      chk("j10a", MEM_END, 8'h10);
      busca(16'h4000, 2'b01, 8'h40, 8'h99);
      chk("branch", MEM_END, 8'h40);
      busca(16'h3000, 2'b10, 8'h00, 8'h10);
      chk("j10b", MEM_END, 8'h10);
      busca(16'h5000, 2'b10, 8'h77, 8'h05);
      chk("jump", MEM_END, 8'h05);
      busca(16'h3000, 2'b10, 8'h00, 8'h10);
      chk("j10c", MEM_END, 8'h10);
      busca(16'h6000, 2'b11, 8'h40, 8'h05);
      chk("fcp11", MEM_END, 8'h11);
      busca(16'h3000, 2'b10, 8'h00, 8'hFF);
      chk("jff", PC, 8'hFF);
      busca(16'h7000, 2'b00, 8'h40, 8'h05);
      chk("wrap", PC, 8'h00);
      busca(16'h8123, 2'b10, 8'h00, 8'h22);
      chk("j22", PC, 8'h22);

      RST_N = 1'b0;
      MEM_PRONTO = 1'b1;
      MEM_DADO = 16'h9999;
      tick();
      chk("mr_instr", INSTR, 0);
      chk("mr_codop", CODOP, 0);
      chk("mr_pc", PC, 0);
      chk("mr_req", MEM_REQ, 0);
      chk("mr_valida", INSTR_VALIDA, 0);
      MEM_PRONTO = 1'b0;
      RST_N = 1'b1;
      tick();
      chk("mr_restart_req", MEM_REQ, 1);
      chk("mr_restart_end", MEM_END, 0);

`ifdef PARADA_EN
      MEM_PRONTO = 1'b1;
      MEM_DADO = 16'hF000;
      tick();
      chk("h_codop", CODOP, 4'hF);
      MEM_PRONTO = 1'b0;
      FONTECP = 2'b00;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("h_req", MEM_REQ, 0);
         chk("h_pc", PC, 0);
         chk("h_valida", INSTR_VALIDA, 0);
         chk("h_instr", INSTR, 16'hF000);
      end
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      tick();
      chk("h_rec_req", MEM_REQ, 1);
      chk("h_rec_instr", INSTR, 0);
`else
      busca(16'hF000, 2'b00, 8'h40, 8'h05);
      chk("nohalt_pc", PC, 8'h01);
      busca(16'h1111, 2'b00, 8'h40, 8'h05);
      chk("nohalt_pc2", PC, 8'h02);
`endif

      $display("Result: errors=%0d of %0d checks", erros, checks);
      $finish;
   end

endmodule
